// File: rtl/alu_req_arbiter_pkg.sv
// alu_req_arbiter_pkg: shared opcode fields, ALU status codes and arbiter FSM states
package alu_req_arbiter_pkg;
  // Opcode [1:0] function select; [2] selects X255 curve, [3] selects the group order N
  localparam logic [1:0] OP_FA  = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_INV = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;
  localparam int SEL_X255 = 2;
  localparam int SEL_N = 3;
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
  // Function code 11 only has a meaning as a swap; without swapop it must never reach the ALU
  function automatic logic op_illegal(input logic [3:0] op, input logic swapop);
    return op[1:0] == OP_ILL && !swapop;
  endfunction
endpackage

// File: rtl/alu_req_arbiter_rr_arbiter.sv
// rr_arbiter: cyclic priority pick of the first set request strictly after the pointer
//   req_i  pending requests     ptr_i  last granted index
//   gnt_o  one-hot grant        idx_o  granted index      any_o  some request is set
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);
  // Walk from farthest to nearest so the nearest set request is the one left standing
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = NREQ; i >= 1; i--) begin
      if (req_i[(int'(ptr_i) + i) % NREQ]) begin
        gnt_o = '0;
        gnt_o[(int'(ptr_i) + i) % NREQ] = 1'b1;
        idx_o = IDW'((int'(ptr_i) + i) % NREQ);
        any_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin sharing of one modular ALU among NREQ requesters
//   req_*   per-requester request/payload, req_ready one-hot accept pulse
//   rsp_*   result strobe tagged with owner id, err on illegal opcode or watchdog timeout
//   alu_*   single-op interface to the ALU (en pulse, held operands, status/vld/results)
//   busy    FSM not idle
module alu_req_arbiter
  import alu_req_arbiter_pkg::*;
#(
  parameter int WID = 256,
  parameter int NREQ = 2,
  parameter int IDW = 1,
  parameter int TOW = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_op,
  input  logic [2*NREQ-1:0] req_swap,
  input  logic [NREQ-1:0]   req_c,
  input  logic [WID*NREQ-1:0] req_a,
  input  logic [WID*NREQ-1:0] req_b,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_err,
  output logic [WID-1:0]    rsp_r,
  output logic [WID-1:0]    rsp_rswap,
  output logic              alu_en,
  output logic [3:0]        alu_opcode,
  output logic              alu_swapop,
  output logic              alu_swapvl,
  output logic              alu_c,
  output logic [WID-1:0]    alu_a,
  output logic [WID-1:0]    alu_b,
  input  logic [1:0]        alu_status,
  input  logic              alu_vld,
  input  logic [WID-1:0]    alu_r,
  input  logic [WID-1:0]    alu_rswap,
  output logic              busy
);
  state_e state_q;
  logic [IDW-1:0] ptr_q, id_q, gidx;
  logic [NREQ-1:0] gnt, ready_q;
  logic gany, en_q, c_q, rsp_valid_q, rsp_err_q;
  logic [3:0] op_q, g_op;
  logic [1:0] sw_q, g_sw;
  logic [WID-1:0] a_q, b_q, r_q, rs_q;
  logic [TOW-1:0] wd_q;
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req_i(req_valid),
    .ptr_i(ptr_q),
    .gnt_o(gnt),
    .idx_o(gidx),
    .any_o(gany)
  );
  assign g_op = req_op[gidx*4 +: 4];
  assign g_sw = req_swap[gidx*2 +: 2];
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q <= IDW'(NREQ - 1);
      id_q <= '0;
      ready_q <= '0;
      en_q <= 1'b0;
      op_q <= '0;
      sw_q <= '0;
      c_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      wd_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q <= 1'b0;
      r_q <= '0;
      rs_q <= '0;
    end else begin
      ready_q <= '0;
      en_q <= 1'b0;
      case (state_q)
        S_IDLE: if (gany) begin
          ready_q <= gnt;
          ptr_q <= gidx;
          id_q <= gidx;
          op_q <= g_op;
          sw_q <= g_sw;
          c_q <= req_c[gidx];
          a_q <= req_a[gidx*WID +: WID];
          b_q <= req_b[gidx*WID +: WID];
          r_q <= '0;
          rs_q <= '0;
          rsp_err_q <= op_illegal(g_op, g_sw[0]);
          state_q <= op_illegal(g_op, g_sw[0]) ? S_RESP : S_ISSUE;
        end
        // The ALU ignores en unless idle, so hold off until it reports idle
        S_ISSUE: if (alu_status == ST_IDLE) begin
          en_q <= 1'b1;
          wd_q <= TOW'(1);
          state_q <= S_WAIT;
        end
        // Watchdog counts WAIT cycles from 1; hitting all-ones abandons the op
        S_WAIT: if (alu_vld) begin
          r_q <= alu_r;
          rs_q <= alu_rswap;
          rsp_valid_q <= 1'b1;
          state_q <= S_RESP;
        end else if (&wd_q) begin
          rsp_err_q <= 1'b1;
          rsp_valid_q <= 1'b1;
          state_q <= S_RESP;
        end else begin
          wd_q <= wd_q + 1'b1;
        end
        // Entered with rsp_valid low only from the illegal-opcode path: strobe next cycle
        S_RESP: if (rsp_valid_q) begin
          rsp_valid_q <= 1'b0;
          state_q <= S_IDLE;
        end else begin
          rsp_valid_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id = id_q;
  assign rsp_err = rsp_err_q;
  assign rsp_r = r_q;
  assign rsp_rswap = rs_q;
  assign alu_en = en_q;
  assign alu_opcode = op_q;
  assign alu_swapop = sw_q[0];
  assign alu_swapvl = sw_q[1];
  assign alu_c = c_q;
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign busy = state_q != S_IDLE;
endmodule
